// File: rtl/mera_bus_pkg.sv
// Shared types and helpers for the MERA-400 system-bus memory responder.
// seg_rank() maps a present segment to its dense slot in block RAM.
package mera_bus_pkg;

   localparam int unsigned BUS_W   = 16;
   localparam int unsigned SEG_CNT = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ACCESS,
      S_DELAY,
      S_ANSWER,
      S_RELEASE
   } bus_state_t;

   // Number of present segments strictly below seg; seg_rank(mask, SEG_CNT) is the population count.
   function automatic int unsigned seg_rank(input logic [SEG_CNT-1:0] mask, input int unsigned seg);
      int unsigned rank;
      rank = 0;
      for (int unsigned i = 0; i < SEG_CNT; i++) begin
         if ((i < seg) && mask[i]) rank++;
      end
      return rank;
   endfunction

endpackage

// File: rtl/bus_sync2.sv
// Generic two-flop synchroniser for asynchronous bus strobes.
// RST_VAL selects the idle level, so active-low strobes reset inactive.
module bus_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mem_bus_slave.sv
// System-bus memory responder: four-phase request/answer handshake over block RAM,
// with segment presence checking and low-memory write protection.
module mem_bus_slave
   import mera_bus_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [15:0] SEG_MASK  = 16'h0001,
   parameter int unsigned ACK_DELAY = 2,
   parameter int unsigned WP_LIMIT  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dw_,
   input  logic        dr_,
   input  logic [0:3]  dnb_,
   input  logic [0:15] dad_,
   input  logic [0:15] ddt_,
   input  logic        dmcl_,
   output logic        rok_,
   output logic        ren_,
   output logic        rpe_,
   output logic [0:15] rdt_
);

   localparam int unsigned SEG_WORDS   = 1 << ADDR_W;
   localparam int unsigned SEG_PRESENT = seg_rank(SEG_MASK, SEG_CNT);
   localparam int unsigned RAM_WORDS   = SEG_PRESENT * SEG_WORDS;
   localparam int unsigned RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [3:0]  CNT_LOAD    = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);

   bus_state_t state_q, state_d;

   logic              wr_sync_n, rd_sync_n, mcl_sync_n;
   logic              wr_req, rd_req, mclr;
   logic [3:0]        seg_q;
   logic [BUS_W-1:0]  addr_q, data_q, rd_data;
   logic              wr_q, reject_q;
   logic [3:0]        cnt_q;
   logic [RAM_AW-1:0] ram_idx_q, ram_idx_dec;
   logic              seg_absent, addr_high, wp_hit, reject_dec;
   logic              ans_active;

   logic [BUS_W-1:0]  mem [RAM_WORDS];

   bus_sync2 #(.RST_VAL(1'b1)) u_sync_dw   (.clk(clk), .rst(rst), .d(dw_),   .q(wr_sync_n));
   bus_sync2 #(.RST_VAL(1'b1)) u_sync_dr   (.clk(clk), .rst(rst), .d(dr_),   .q(rd_sync_n));
   bus_sync2 #(.RST_VAL(1'b1)) u_sync_dmcl (.clk(clk), .rst(rst), .d(dmcl_), .q(mcl_sync_n));

   assign wr_req = !wr_sync_n;
   assign rd_req = !rd_sync_n;
   assign mclr   = !mcl_sync_n;

   assign seg_absent = !SEG_MASK[seg_q];
   assign addr_high  = (ADDR_W < BUS_W) ? ((addr_q >> ADDR_W) != '0) : 1'b0;

   generate
      if (WP_LIMIT == 0) begin : g_no_wp
         assign wp_hit = 1'b0;
      end else begin : g_wp
         assign wp_hit = wr_q && (seg_q == '0) && (32'(addr_q) < WP_LIMIT);
      end
   endgenerate

   assign reject_dec  = seg_absent || addr_high || wp_hit;
   assign ram_idx_dec = RAM_AW'(seg_rank(SEG_MASK, 32'(seg_q)) * SEG_WORDS) + RAM_AW'(addr_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (wr_req || rd_req) state_d = (wr_req && rd_req) ? S_ANSWER : S_DECODE;
         S_DECODE:  state_d = reject_dec ? S_ANSWER : S_ACCESS;
         S_ACCESS:  state_d = (ACK_DELAY == 0) ? S_ANSWER : S_DELAY;
         S_DELAY:   if (cnt_q == '0) state_d = S_ANSWER;
         S_ANSWER:  state_d = S_RELEASE;
         S_RELEASE: if (!wr_req && !rd_req) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (mclr) state_d = S_IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         wr_q      <= 1'b0;
         reject_q  <= 1'b0;
         cnt_q     <= '0;
         ram_idx_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // Bus lines are stable while the strobe is held, so one capture suffices.
               if (wr_req || rd_req) begin
                  seg_q    <= ~dnb_;
                  addr_q   <= ~dad_;
                  data_q   <= ~ddt_;
                  wr_q     <= wr_req;
                  reject_q <= wr_req && rd_req;
               end
            end
            S_DECODE: begin
               reject_q  <= reject_dec;
               ram_idx_q <= ram_idx_dec;
            end
            S_ACCESS: cnt_q <= CNT_LOAD;
            S_DELAY:  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            default:  ;
         endcase
      end
   end

   // Only ACCESS touches the array, which makes the write happen once per handshake.
   always_ff @(posedge clk) begin
      if ((state_q == S_ACCESS) && !mclr) begin
         if (wr_q) mem[ram_idx_q] <= data_q;
         else      rd_data        <= mem[ram_idx_q];
      end
   end

   assign ans_active = (state_q == S_ANSWER) || (state_q == S_RELEASE);
   assign rok_ = !(ans_active && !reject_q);
   assign ren_ = !(ans_active && reject_q);
   assign rpe_ = 1'b1;
   assign rdt_ = (ans_active && !reject_q && !wr_q) ? ~rd_data : '1;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Directed self-checking bench for mem_bus_slave (SEG_MASK=1, ACK_DELAY=2, WP_LIMIT=16).
module tb_mem_bus_slave;
   import mera_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        dw_, dr_, dmcl_;
   logic [0:3]  dnb_;
   logic [0:15] dad_, ddt_;
   logic        rok_, ren_, rpe_;
   logic [0:15] rdt_;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_slave #(
      .ADDR_W(12),
      .SEG_MASK(16'h0001),
      .ACK_DELAY(2),
      .WP_LIMIT(16)
   ) dut (
      .clk(clk), .rst(rst), .dw_(dw_), .dr_(dr_), .dnb_(dnb_), .dad_(dad_),
      .ddt_(ddt_), .dmcl_(dmcl_), .rok_(rok_), .ren_(ren_), .rpe_(rpe_), .rdt_(rdt_)
   );

   always #5 clk = ~clk;

   // Issues a request and waits (bounded) for an answer; lat=40 means no answer.
   task automatic bus_req(input logic do_w, input logic do_r, input logic [3:0] seg,
                          input logic [15:0] addr, input logic [15:0] data,
                          output int lat, output logic ok_seen, output logic en_seen,
                          output logic [15:0] rd);
      dnb_ = ~seg;
      dad_ = ~addr;
      ddt_ = ~data;
      dw_  = !do_w;
      dr_  = !do_r;
      lat  = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (!rok_ || !ren_) break;
      end
      ok_seen = !rok_;
      en_seen = !ren_;
      rd      = rdt_;
   endtask

   task automatic bus_release(output int rel);
      dw_ = 1'b1;
      dr_ = 1'b1;
      rel = 0;
      while (rel < 10) begin
         @(posedge clk); #1;
         rel++;
         if (rok_ && ren_) break;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; dw_ = 1'b1; dr_ = 1'b1; dmcl_ = 1'b1;
      dnb_ = '1; dad_ = '1; ddt_ = '1;
      #1;
      n_checks++;
      if ({rok_, ren_, rpe_} !== 3'b111) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 111", {rok_, ren_, rpe_});
      end
      n_checks++;
      if (rdt_ !== 16'hffff) begin
         n_fail++; $display("FAIL reset_rdt: got %h expected ffff", rdt_);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (dut.state_q !== S_IDLE || rok_ !== 1'b1 || ren_ !== 1'b1) begin
         n_fail++; $display("FAIL reset_idle: state %0d rok %b ren %b expected IDLE 1 1", dut.state_q, rok_, ren_);
      end
   endtask

   task automatic test_write_read();
      int lat, rel; logic ok, en; logic [15:0] rd;
      bus_req(1'b1, 1'b0, 4'd0, 16'h0010, 16'h1234, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || ok !== 1'b1 || en !== 1'b0) begin
         n_fail++; $display("FAIL wr_answer: lat %0d ok %b en %b expected 7 1 0", lat, ok, en);
      end
      n_checks++;
      if (rd !== 16'hffff) begin
         n_fail++; $display("FAIL wr_rdt: got %h expected ffff", rd);
      end
      bus_release(rel);
      n_checks++;
      if (rel > 3 || rok_ !== 1'b1 || rdt_ !== 16'hffff) begin
         n_fail++; $display("FAIL wr_release: %0d clk rok %b rdt %h expected <=3 1 ffff", rel, rok_, rdt_);
      end
      bus_req(1'b0, 1'b1, 4'd0, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || ok !== 1'b1 || en !== 1'b0) begin
         n_fail++; $display("FAIL rd_answer: lat %0d ok %b en %b expected 7 1 0", lat, ok, en);
      end
      n_checks++;
      if (rd !== 16'hedcb) begin
         n_fail++; $display("FAIL rd_data: got %h expected edcb", rd);
      end
      bus_release(rel);
      n_checks++;
      if (rdt_ !== 16'hffff) begin
         n_fail++; $display("FAIL rd_release_rdt: got %h expected ffff", rdt_);
      end
   endtask

   task automatic test_rejects();
      int lat, rel; logic ok, en; logic [15:0] rd;
      bus_req(1'b0, 1'b1, 4'd3, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 4 || en !== 1'b1 || ok !== 1'b0) begin
         n_fail++; $display("FAIL absent_seg: lat %0d ok %b en %b expected 4 0 1", lat, ok, en);
      end
      n_checks++;
      if (rd !== 16'hffff) begin
         n_fail++; $display("FAIL absent_seg_rdt: got %h expected ffff", rd);
      end
      bus_release(rel);
      bus_req(1'b0, 1'b1, 4'd0, 16'h1000, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 4 || en !== 1'b1 || ok !== 1'b0) begin
         n_fail++; $display("FAIL addr_range: lat %0d ok %b en %b expected 4 0 1", lat, ok, en);
      end
      bus_release(rel);
      bus_req(1'b1, 1'b1, 4'd0, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 3 || en !== 1'b1 || ok !== 1'b0) begin
         n_fail++; $display("FAIL both_strobes: lat %0d ok %b en %b expected 3 0 1", lat, ok, en);
      end
      bus_release(rel);
   endtask

   task automatic test_write_protect();
      int lat, rel; logic ok, en; logic [15:0] rd, base;
      bus_req(1'b0, 1'b1, 4'd0, 16'h0005, 16'h0000, lat, ok, en, rd);
      base = ~rd;
      n_checks++;
      if (lat !== 7 || ok !== 1'b1) begin
         n_fail++; $display("FAIL wp_base_read: lat %0d ok %b expected 7 1", lat, ok);
      end
      bus_release(rel);
      bus_req(1'b1, 1'b0, 4'd0, 16'h0005, ~base, lat, ok, en, rd);
      n_checks++;
      if (lat !== 4 || en !== 1'b1 || ok !== 1'b0) begin
         n_fail++; $display("FAIL wp_addr5: lat %0d ok %b en %b expected 4 0 1", lat, ok, en);
      end
      bus_release(rel);
      bus_req(1'b1, 1'b0, 4'd0, 16'h000f, 16'h5555, lat, ok, en, rd);
      n_checks++;
      if (en !== 1'b1 || ok !== 1'b0) begin
         n_fail++; $display("FAIL wp_addr15: ok %b en %b expected 0 1", ok, en);
      end
      bus_release(rel);
      bus_req(1'b0, 1'b1, 4'd0, 16'h0005, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (ok !== 1'b1 || ~rd !== base) begin
         n_fail++; $display("FAIL wp_preserved: ok %b data %h expected 1 %h", ok, ~rd, base);
      end
      bus_release(rel);
   endtask

   task automatic test_hold();
      int lat, rel, bad; logic ok, en; logic [15:0] rd;
      bus_req(1'b1, 1'b0, 4'd0, 16'h0020, 16'h5a5a, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || ok !== 1'b1) begin
         n_fail++; $display("FAIL hold_answer: lat %0d ok %b expected 7 1", lat, ok);
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         if (i == 10) ddt_ = 16'h0000;
         @(posedge clk); #1;
         if (rok_ !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL hold_rok: %0d cycles released expected 0", bad);
      end
      bus_release(rel);
      n_checks++;
      if (rel > 3 || rok_ !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: %0d clk rok %b expected <=3 1", rel, rok_);
      end
      bus_req(1'b0, 1'b1, 4'd0, 16'h0020, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (rd !== 16'ha5a5) begin
         n_fail++; $display("FAIL hold_single_write: got %h expected a5a5", rd);
      end
      bus_release(rel);
   endtask

   task automatic test_back_to_back();
      int lat, rel; logic ok, en; logic [15:0] rd;
      bus_req(1'b1, 1'b0, 4'd0, 16'h0011, 16'hbeef, lat, ok, en, rd);
      bus_release(rel);
      bus_req(1'b1, 1'b0, 4'd0, 16'h0fff, 16'h0f0f, lat, ok, en, rd);
      bus_release(rel);
      bus_req(1'b0, 1'b1, 4'd0, 16'h0011, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (rd !== 16'h4110) begin
         n_fail++; $display("FAIL b2b_first: got %h expected 4110", rd);
      end
      bus_release(rel);
      bus_req(1'b0, 1'b1, 4'd0, 16'h0fff, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || rd !== 16'hf0f0) begin
         n_fail++; $display("FAIL b2b_top_addr: lat %0d data %h expected 7 f0f0", lat, rd);
      end
      bus_release(rel);
   endtask

   task automatic test_master_clear();
      int lat, rel, bad; logic ok, en; logic [15:0] rd;
      dnb_ = ~4'd0; dad_ = ~16'h0010; dr_ = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      n_checks++;
      if (dut.state_q !== S_DELAY) begin
         n_fail++; $display("FAIL mclr_setup: state %0d expected DELAY", dut.state_q);
      end
      dmcl_ = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (rok_ !== 1'b1 || ren_ !== 1'b1 || rdt_ !== 16'hffff || dut.state_q !== S_IDLE) begin
         n_fail++; $display("FAIL mclr_abort: rok %b ren %b rdt %h state %0d expected 1 1 ffff IDLE", rok_, ren_, rdt_, dut.state_q);
      end
      dr_ = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (!rok_ || !ren_) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL mclr_quiet: %0d answer cycles expected 0", bad);
      end
      dmcl_ = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      bus_req(1'b0, 1'b1, 4'd0, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || ok !== 1'b1 || rd !== 16'hedcb) begin
         n_fail++; $display("FAIL mclr_next: lat %0d ok %b data %h expected 7 1 edcb", lat, ok, rd);
      end
      bus_release(rel);
   endtask

   task automatic test_async_reset();
      int lat, rel; logic ok, en; logic [15:0] rd;
      bus_req(1'b0, 1'b1, 4'd0, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (ok !== 1'b1 || dut.state_q !== S_ANSWER) begin
         n_fail++; $display("FAIL arst_setup: ok %b state %0d expected 1 ANSWER", ok, dut.state_q);
      end
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({rok_, ren_, rpe_} !== 3'b111 || rdt_ !== 16'hffff) begin
         n_fail++; $display("FAIL arst_outputs: strobes %b rdt %h expected 111 ffff", {rok_, ren_, rpe_}, rdt_);
      end
      dr_ = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus_req(1'b0, 1'b1, 4'd0, 16'h0010, 16'h0000, lat, ok, en, rd);
      n_checks++;
      if (lat !== 7 || rd !== 16'hedcb) begin
         n_fail++; $display("FAIL arst_ram_kept: lat %0d data %h expected 7 edcb", lat, rd);
      end
      bus_release(rel);
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_rejects();
      test_write_protect();
      test_hold();
      test_back_to_back();
      test_master_clear();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
